// File: rtl/dbus_wbuf.sv
// Data-bus interface: posted write buffer plus in-order load servicing over a req/ack bus.
// Latency: a store is queued on its M-cycle edge; load data is on DBUSMUPIN the cycle after BUS_ACK.
// Backpressure: DBIU_HALT is high while a load is outstanding or an M store meets a full buffer.
// Optional: DBUS_WBUF_MERGE_EN merges an M store into the tail entry when the word addresses match.
module dbus_wbuf #(
    parameter int WB_DEPTH = 4,
    parameter int WB_PTRW  = 2
) (
    input  logic        SYSCLK,
    input  logic        RESET1N,
    input  logic [31:0] RALU_DADDR_E,
    input  logic        RALU_DREAD_E_R,
    input  logic        RALU_DWRITE_E_R,
    input  logic        RALU_DSIGN_E_R,
    input  logic [3:0]  RALU_DBYEN_E,
    input  logic        RALU_DWORD_E,
    input  logic [31:0] RALU_ADATAREG_M_R,
    input  logic        CP0_XCPN_M,
    output logic [31:0] DBUSMUPIN,
    output logic        DBIU_HALT,
    output logic        BUS_REQ,
    output logic        BUS_WR,
    output logic [31:0] BUS_ADDR,
    output logic [3:0]  BUS_BYEN,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR_BUSY = 2'd1, RD_BUSY = 2'd2} state_t;
    state_t state;

    logic [29:0] fifo_addr [WB_DEPTH];
    logic [3:0]  fifo_byen [WB_DEPTH];
    logic [31:0] fifo_data [WB_DEPTH];
    logic [WB_PTRW:0]   wr_ptr, rd_ptr;
    logic [WB_PTRW-1:0] wr_idx, rd_idx;
    logic fifo_empty, fifo_full;

    logic        pend_vld, pend_held;
    logic [29:0] pend_addr;
    logic [3:0]  pend_byen;
    logic [31:0] pend_data;

    logic        ld_done, ld_sign, ld_word;
    logic [3:0]  ld_byen;

    logic [3:0]  e_byen;
    logic [31:0] m_data;
    logic ld_req, push_req, merge, push, pop, blocked, halt, e_cap;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^RALU_DADDR_E[1:0];

    assign wr_idx     = wr_ptr[WB_PTRW-1:0];
    assign rd_idx     = rd_ptr[WB_PTRW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[WB_PTRW] != rd_ptr[WB_PTRW]) && (wr_idx == rd_idx);

    assign e_byen   = RALU_DWORD_E ? 4'hF : RALU_DBYEN_E;
    // A store takes precedence over a load presented in the same E cycle.
    assign ld_req   = RALU_DREAD_E_R && !RALU_DWRITE_E_R && !ld_done;
    // The exception only applies in the store's first M cycle; a held store is already committed.
    assign push_req = pend_vld && !(CP0_XCPN_M && !pend_held);
    assign m_data   = pend_held ? pend_data : RALU_ADATAREG_M_R;
    assign pop      = (state == WR_BUSY) && BUS_ACK;

`ifdef DBUS_WBUF_MERGE_EN
    logic [WB_PTRW-1:0] tail_idx;
    logic [31:0]        merge_mask;
    assign tail_idx   = wr_idx - WB_PTRW'(1);
    // The head entry is on (or about to go on) the bus, so only a non-head tail may absorb a store.
    assign merge      = push_req && !fifo_empty && (tail_idx != rd_idx) &&
                        (fifo_addr[tail_idx] == pend_addr);
    assign merge_mask = {{8{pend_byen[3]}}, {8{pend_byen[2]}}, {8{pend_byen[1]}}, {8{pend_byen[0]}}};
`else
    assign merge = 1'b0;
`endif

    assign push      = push_req && !merge && (!fifo_full || pop);
    assign blocked   = push_req && !merge && fifo_full && !pop;
    assign halt      = blocked || ld_req;
    assign DBIU_HALT = halt;
    assign e_cap     = RALU_DWRITE_E_R && !halt;

    function automatic logic [31:0] ld_align(input logic [31:0] d, input logic [3:0] be,
                                             input logic word, input logic sgn);
        logic [31:0] r;
        r = d;
        if (!word) begin
            case (be)
                4'b0011: r = {{16{sgn & d[15]}}, d[15:0]};
                4'b1100: r = {{16{sgn & d[31]}}, d[31:16]};
                4'b0001: r = {{24{sgn & d[7]}},  d[7:0]};
                4'b0010: r = {{24{sgn & d[15]}}, d[15:8]};
                4'b0100: r = {{24{sgn & d[23]}}, d[23:16]};
                4'b1000: r = {{24{sgn & d[31]}}, d[31:24]};
                default: r = d;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge SYSCLK) begin
        if (push) begin
            fifo_addr[wr_idx] <= pend_addr;
            fifo_byen[wr_idx] <= pend_byen;
            fifo_data[wr_idx] <= m_data;
        end
`ifdef DBUS_WBUF_MERGE_EN
        if (merge) begin
            fifo_byen[tail_idx] <= fifo_byen[tail_idx] | pend_byen;
            fifo_data[tail_idx] <= (fifo_data[tail_idx] & ~merge_mask) | (m_data & merge_mask);
        end
`endif
    end

    always_ff @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pend_vld  <= 1'b0;
            pend_held <= 1'b0;
            pend_addr <= '0;
            pend_byen <= '0;
            pend_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (WB_PTRW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (WB_PTRW+1)'(1);
            if (blocked) begin
                pend_held <= 1'b1;
                pend_data <= m_data;
            end else begin
                pend_vld  <= e_cap;
                pend_held <= 1'b0;
                if (e_cap) begin
                    pend_addr <= RALU_DADDR_E[31:2];
                    pend_byen <= e_byen;
                end
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            state     <= IDLE;
            BUS_REQ   <= 1'b0;
            BUS_WR    <= 1'b0;
            BUS_ADDR  <= '0;
            BUS_BYEN  <= '0;
            BUS_WDATA <= '0;
            DBUSMUPIN <= '0;
            ld_done   <= 1'b0;
            ld_sign   <= 1'b0;
            ld_word   <= 1'b0;
            ld_byen   <= '0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Reads wait until every queued and in-flight store has drained.
                    if (ld_req && fifo_empty && !pend_vld) begin
                        state    <= RD_BUSY;
                        BUS_REQ  <= 1'b1;
                        BUS_WR   <= 1'b0;
                        BUS_ADDR <= {RALU_DADDR_E[31:2], 2'b00};
                        BUS_BYEN <= e_byen;
                        ld_byen  <= e_byen;
                        ld_sign  <= RALU_DSIGN_E_R;
                        ld_word  <= RALU_DWORD_E;
                    end else if (!fifo_empty) begin
                        state     <= WR_BUSY;
                        BUS_REQ   <= 1'b1;
                        BUS_WR    <= 1'b1;
                        BUS_ADDR  <= {fifo_addr[rd_idx], 2'b00};
                        BUS_BYEN  <= fifo_byen[rd_idx];
                        BUS_WDATA <= fifo_data[rd_idx];
                    end
                end
                WR_BUSY: begin
                    if (BUS_ACK) begin
                        state   <= IDLE;
                        BUS_REQ <= 1'b0;
                        BUS_WR  <= 1'b0;
                    end
                end
                RD_BUSY: begin
                    if (BUS_ACK) begin
                        state     <= IDLE;
                        BUS_REQ   <= 1'b0;
                        DBUSMUPIN <= ld_align(BUS_RDATA, ld_byen, ld_word, ld_sign);
                        ld_done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_wbuf.sv
// Directed bench for dbus_wbuf: queue-based store scoreboard, load-result model, per-cycle bus checks.
module tb_dbus_wbuf;
    logic        SYSCLK = 1'b0;
    logic        RESET1N = 1'b0;
    logic [31:0] RALU_DADDR_E = '0;
    logic        RALU_DREAD_E_R = 1'b0;
    logic        RALU_DWRITE_E_R = 1'b0;
    logic        RALU_DSIGN_E_R = 1'b0;
    logic [3:0]  RALU_DBYEN_E = '0;
    logic        RALU_DWORD_E = 1'b0;
    logic [31:0] RALU_ADATAREG_M_R = '0;
    logic        CP0_XCPN_M = 1'b0;
    logic [31:0] DBUSMUPIN;
    logic        DBIU_HALT;
    logic        BUS_REQ, BUS_WR;
    logic [31:0] BUS_ADDR, BUS_WDATA;
    logic [3:0]  BUS_BYEN;
    logic        BUS_ACK = 1'b0;
    logic [31:0] BUS_RDATA = '0;

    dbus_wbuf #(.WB_DEPTH(4), .WB_PTRW(2)) dut (
        .SYSCLK(SYSCLK), .RESET1N(RESET1N),
        .RALU_DADDR_E(RALU_DADDR_E), .RALU_DREAD_E_R(RALU_DREAD_E_R),
        .RALU_DWRITE_E_R(RALU_DWRITE_E_R), .RALU_DSIGN_E_R(RALU_DSIGN_E_R),
        .RALU_DBYEN_E(RALU_DBYEN_E), .RALU_DWORD_E(RALU_DWORD_E),
        .RALU_ADATAREG_M_R(RALU_ADATAREG_M_R), .CP0_XCPN_M(CP0_XCPN_M),
        .DBUSMUPIN(DBUSMUPIN), .DBIU_HALT(DBIU_HALT),
        .BUS_REQ(BUS_REQ), .BUS_WR(BUS_WR), .BUS_ADDR(BUS_ADDR), .BUS_BYEN(BUS_BYEN),
        .BUS_WDATA(BUS_WDATA), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  byen;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_dbus = '0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_byen = '0;
    logic        ld_sign = 1'b0;
    logic [31:0] rd_data = '0;
    logic [3:0]  byen_500 = '0;
    logic [31:0] wdata_500 = '0;
    int n_tests = 0, n_fail = 0, cyc = 0, rd_ack_cyc = -1, n_wr = 0;
    int ack_gap = 0, ack_cnt = 0;
    int hc = 0, hc5 = 0, base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m |= 32'hFF << (8 * i);
        return m;
    endfunction

    // Load result from first principles: width = number of enabled lanes, shifted down, then extended.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [3:0] be, input logic sgn);
        int lo = 0, n = 0;
        logic [31:0] v, m;
        for (int i = 0; i < 4; i++) if (be[i]) begin
            if (n == 0) lo = i;
            n++;
        end
        if (n == 4) return rd;
        v = rd >> (8 * lo);
        m = (32'h1 << (8 * n)) - 32'h1;
        v = v & m;
        if (sgn && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic model_push(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        wr_t t;
`ifdef DBUS_WBUF_MERGE_EN
        if (exp_q.size() >= 2 && exp_q[exp_q.size()-1].addr[31:2] == addr[31:2]) begin
            t = exp_q[exp_q.size()-1];
            t.byen = t.byen | be;
            t.data = (t.data & ~lane_mask(be)) | (data & lane_mask(be));
            exp_q[exp_q.size()-1] = t;
            return;
        end
`endif
        t.addr = addr; t.byen = be; t.data = data;
        exp_q.push_back(t);
    endtask

    // Scoreboard: every completed bus transaction is checked against the model at the ACK edge.
    always @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            exp_q.delete();
            exp_dbus = '0;
        end else begin
            cyc++;
            if (BUS_REQ && BUS_ACK) begin
                if (BUS_WR) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%08h, expected no write", BUS_ADDR);
                    end else begin
                        chk("wr_addr", BUS_ADDR, {exp_q[0].addr[31:2], 2'b00});
                        chk("wr_byen", {28'h0, BUS_BYEN}, {28'h0, exp_q[0].byen});
                        chk("wr_data", BUS_WDATA & lane_mask(exp_q[0].byen), exp_q[0].data & lane_mask(exp_q[0].byen));
                        void'(exp_q.pop_front());
                    end
                    n_wr++;
                    if (BUS_ADDR == 32'h500) begin byen_500 = BUS_BYEN; wdata_500 = BUS_WDATA; end
                end else begin
                    chk("rd_after_stores", exp_q.size(), 0);
                    chk("rd_addr", BUS_ADDR, {ld_addr[31:2], 2'b00});
                    chk("rd_byen", {28'h0, BUS_BYEN}, {28'h0, ld_byen});
                    exp_dbus = model_load(BUS_RDATA, ld_byen, ld_sign);
                    rd_ack_cyc = cyc;
                end
            end
        end
    end

    logic        prev_hold = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [3:0]  p_byen = '0;
    always @(negedge SYSCLK) begin
        chk("dbusmupin", DBUSMUPIN, exp_dbus);
        chk("bus_addr_lsb", {30'h0, BUS_ADDR[1:0]}, 32'h0);
        if (prev_hold && BUS_REQ) begin
            chk("hold_addr", BUS_ADDR, p_addr);
            chk("hold_byen", {28'h0, BUS_BYEN}, {28'h0, p_byen});
            chk("hold_wr", {31'h0, BUS_WR}, {31'h0, p_wr});
            if (BUS_WR) chk("hold_wdata", BUS_WDATA, p_wdata);
        end
        prev_hold = BUS_REQ && !BUS_ACK;
        p_addr = BUS_ADDR; p_byen = BUS_BYEN; p_wr = BUS_WR; p_wdata = BUS_WDATA;
    end

    // Memory responder: acknowledges a request after ack_gap cycles of BUS_REQ (0 = stall forever).
    initial forever begin
        @(posedge SYSCLK); #1;
        if (BUS_ACK) BUS_ACK = 1'b0;
        else if (BUS_REQ && ack_gap > 0) begin
            ack_cnt++;
            if (ack_cnt >= ack_gap) begin
                BUS_ACK = 1'b1;
                BUS_RDATA = BUS_WR ? 32'h0 : rd_data;
                ack_cnt = 0;
            end
        end else ack_cnt = 0;
    end

    task automatic do_store(input logic [31:0] addr, input logic [3:0] be, input logic word,
                            input logic [31:0] data, input logic xcpn, output int halt_cycles);
        int g = 0;
        @(posedge SYSCLK); #1;
        RALU_DADDR_E = addr; RALU_DBYEN_E = be; RALU_DWORD_E = word; RALU_DWRITE_E_R = 1'b1;
        @(negedge SYSCLK);
        while (DBIU_HALT && g < 2000) begin @(negedge SYSCLK); g++; end
        @(posedge SYSCLK); #1;
        RALU_DWRITE_E_R = 1'b0; RALU_ADATAREG_M_R = data; CP0_XCPN_M = xcpn;
        if (!xcpn) model_push(addr, word ? 4'hF : be, data);
        halt_cycles = 0;
        @(negedge SYSCLK);
        while (DBIU_HALT && halt_cycles < 2000) begin halt_cycles++; @(negedge SYSCLK); end
        if (halt_cycles >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL store_halt_timeout: got halt stuck, expected release");
        end else if (halt_cycles > 0) chk("halt_clear_on_pop", {31'h0, BUS_ACK && BUS_WR}, 32'h1);
        @(posedge SYSCLK); #1;
        CP0_XCPN_M = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] be, input logic word,
                           input logic sgn, input logic [31:0] rdat, input logic [31:0] exp_lit,
                           input string name);
        int g = 0;
        @(posedge SYSCLK); #1;
        rd_data = rdat; ld_addr = addr; ld_byen = word ? 4'hF : be; ld_sign = sgn;
        RALU_DADDR_E = addr; RALU_DBYEN_E = be; RALU_DWORD_E = word;
        RALU_DSIGN_E_R = sgn; RALU_DREAD_E_R = 1'b1;
        @(negedge SYSCLK);
        chk("ld_halt_e", {31'h0, DBIU_HALT}, 32'h1);
        while (DBIU_HALT && g < 2000) begin @(negedge SYSCLK); g++; end
        if (g >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL load_timeout %s: got halt stuck, expected release", name);
        end
        chk("halt_drop_after_ack", cyc, rd_ack_cyc);
        @(posedge SYSCLK); #1;
        RALU_DREAD_E_R = 1'b0; RALU_DSIGN_E_R = 1'b0;
        @(negedge SYSCLK);
        chk(name, DBUSMUPIN, exp_lit);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || BUS_REQ) && g < 3000) begin @(negedge SYSCLK); g++; end
        n_tests++;
        if (g >= 3000) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK);
        chk("rst_req", {31'h0, BUS_REQ}, 32'h0);
        chk("rst_halt", {31'h0, DBIU_HALT}, 32'h0);
        chk("rst_dbus", DBUSMUPIN, 32'h0);
        RESET1N = 1'b1;

        // Fill the buffer with the bus stalled, then drain with an ack every third cycle.
        ack_gap = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h100 + 4 * i, 4'h0, 1'b1, 32'hA000_0000 + i, 1'b0, hc);
            chk("no_halt_when_room", hc, 0);
        end
        base = n_wr;
        fork
            do_store(32'h110, 4'h0, 1'b1, 32'hA000_0004, 1'b0, hc5);
            begin repeat (6) @(posedge SYSCLK); ack_gap = 3; end
        join
        chk("full_halts_5th", {31'h0, hc5 > 0}, 32'h1);
        drain();
        chk("five_writes", n_wr - base, 5);

        // Killed store must never reach the bus.
        base = n_wr;
        do_store(32'h200, 4'h0, 1'b1, 32'hDEAD_0200, 1'b1, hc);
        repeat (10) @(negedge SYSCLK);
        chk("xcpn_no_write", n_wr - base, 0);
        chk("xcpn_req_idle", {31'h0, BUS_REQ}, 32'h0);

        ack_gap = 2;
        do_store(32'h300, 4'h0, 1'b1, 32'h1122_3344, 1'b0, hc);
        do_load(32'h303, 4'b1000, 1'b0, 1'b1, 32'h8022_3344, 32'hFFFF_FF80, "ld_sb_303");
        do_load(32'h402, 4'b1100, 1'b0, 1'b0, 32'hBEEF_1234, 32'h0000_BEEF, "ld_uh_402");
        do_load(32'h400, 4'b0011, 1'b0, 1'b1, 32'h0000_8001, 32'hFFFF_8001, "ld_sh_400");
        do_load(32'h401, 4'b0010, 1'b0, 1'b0, 32'h0000_AB00, 32'h0000_00AB, "ld_ub_401");
        do_load(32'h404, 4'h0, 1'b1, 1'b1, 32'h8765_4321, 32'h8765_4321, "ld_w_404");

        // Byte stores to the same word behind a stalled write.
        ack_gap = 0;
        base = n_wr;
        do_store(32'h600, 4'h0, 1'b1, 32'h6666_6666, 1'b0, hc);
        do_store(32'h500, 4'b0001, 1'b0, 32'h0000_00AA, 1'b0, hc);
        do_store(32'h502, 4'b0100, 1'b0, 32'h00CC_0000, 1'b0, hc);
        chk("merge_no_halt", hc, 0);
`ifdef DBUS_WBUF_MERGE_EN
        chk("merge_model_entries", exp_q.size(), 2);
`else
        chk("merge_model_entries", exp_q.size(), 3);
`endif
        ack_gap = 1;
        drain();
`ifdef DBUS_WBUF_MERGE_EN
        chk("merge_writes", n_wr - base, 2);
        chk("merge_byen", {28'h0, byen_500}, 32'h5);
        chk("merge_wdata", wdata_500 & 32'h00FF_00FF, 32'h00CC_00AA);
`else
        chk("merge_writes", n_wr - base, 3);
        chk("merge_byen", {28'h0, byen_500}, 32'h4);
        chk("merge_wdata", wdata_500 & 32'h00FF_0000, 32'h00CC_0000);
`endif

        // Asynchronous reset in the middle of a stalled write.
        ack_gap = 0;
        do_store(32'h700, 4'h0, 1'b1, 32'h7777_7777, 1'b0, hc);
        hc = 0;
        while (!BUS_REQ && hc < 20) begin @(negedge SYSCLK); hc++; end
        chk("pre_reset_req", {31'h0, BUS_REQ}, 32'h1);
        @(posedge SYSCLK); #3;
        RESET1N = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, BUS_REQ}, 32'h0);
        chk("mid_rst_halt", {31'h0, DBIU_HALT}, 32'h0);
        chk("mid_rst_dbus", DBUSMUPIN, 32'h0);
        @(posedge SYSCLK); #1;
        RESET1N = 1'b1;
        ack_gap = 1;
        base = n_wr;
        repeat (10) @(negedge SYSCLK);
        chk("post_rst_empty", n_wr - base, 0);
        chk("post_rst_req", {31'h0, BUS_REQ}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/dbus_wbuf.md
Name: dbus_wbuf

Overview:
- Data-bus interface and posted write buffer, directly downstream of the core's E/M-stage load/store outputs.
- Captures E-stage load/store requests and M-stage store data.
- Queues stores in a FIFO and drains them over a simple req/ack memory bus.
- Services loads in program order, returns aligned and extended load data to the core, and stalls the core whenever a request cannot be accepted.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of two, 2..16.
- WB_PTRW, 2, pointer width; must equal log2(WB_DEPTH).

Ports:
- SYSCLK  in  1  core clock; all state rises on posedge.
- RESET1N  in  1  asynchronous active-low reset.
- RALU_DADDR_E  in  32  E-stage data address.
- RALU_DREAD_E_R  in  1  E-stage load request.
- RALU_DWRITE_E_R  in  1  E-stage store request.
- RALU_DSIGN_E_R  in  1  load sign-extend enable.
- RALU_DBYEN_E  in  4  byte enables, bit i = lane [8i+7:8i].
- RALU_DWORD_E  in  1  full-word access.
- RALU_ADATAREG_M_R  in  32  store data, valid in the M cycle following the E request.
- CP0_XCPN_M  in  1  M-stage exception; kills the store currently in M.
- DBUSMUPIN  out  32  aligned, extended load data to the core.
- DBIU_HALT  out  1  core stall; core holds all E/M inputs stable while high.
- BUS_REQ  out  1  bus request.
- BUS_WR  out  1  1 = write, 0 = read.
- BUS_ADDR  out  32  word address, bits [1:0] forced to 0.
- BUS_BYEN  out  4  byte enables.
- BUS_WDATA  out  32  write data.
- BUS_ACK  in  1  transaction complete.
- BUS_RDATA  in  32  read data, valid with BUS_ACK.

Behaviour:
- Reset (RESET1N low, asynchronous):
  - FIFO emptied, pending-store slot cleared, FSM to IDLE.
  - All outputs 0.
  - Reset mid-transaction aborts BUS_REQ immediately; queued stores are lost.
- Store path:
  - E cycle with RALU_DWRITE_E_R=1 and DBIU_HALT=0 loads the pending slot with addr[31:2] and byen (byen=4'hF when RALU_DWORD_E=1).
  - Next (M) cycle:
    - CP0_XCPN_M=1: slot discarded.
    - Otherwise the slot plus RALU_ADATAREG_M_R is pushed to the FIFO.
    - FIFO full with no pop this cycle: DBIU_HALT=1 and the slot retains addr/byen/data until a pop frees an entry.
    - Pop and push in the same cycle on a full FIFO: push accepted, no halt.
- FSM:
  - IDLE: if a load is pending and the FIFO is empty and no push occurs this cycle, go to RD_BUSY. Otherwise, if the FIFO is non-empty, go to WR_BUSY.
  - WR_BUSY: BUS_REQ=1, BUS_WR=1, head entry on BUS_ADDR/BYEN/WDATA, held stable until BUS_ACK. On ACK: pop, return to IDLE. A new request may issue the cycle after ACK.
  - RD_BUSY: BUS_REQ=1, BUS_WR=0, BUS_BYEN = access byen. On ACK: latch BUS_RDATA, go to IDLE.
- Load path:
  - RALU_DREAD_E_R=1 raises DBIU_HALT in that E cycle.
  - Strict ordering: all queued and pending stores drain before the read issues.
  - DBIU_HALT drops the cycle after the read ACK. DBUSMUPIN is valid in the following cycle and holds until the next load completes.
- Load alignment:
  - Word (DWORD=1): passed through.
  - Halfword (byen 0011/1100): selected lane moved to [15:0].
  - Byte (one-hot byen): selected lane moved to [7:0].
  - Upper bits are sign-extended when RALU_DSIGN_E_R=1, else zero-filled.
- Pointer wrap: read/write pointers wrap modulo WB_DEPTH; an extra wrap bit distinguishes full from empty.
- Simultaneous load and store request in the same E cycle is illegal; the store takes precedence.
- BUS_ACK outside WR_BUSY/RD_BUSY is ignored.

Optional Feature:
- Macro: DBUS_WBUF_MERGE_EN.
- Defined: an M-stage push whose word address equals the FIFO tail entry's address, while that entry is not being driven on the bus, merges into it instead of allocating. Byte lanes are ORed, enabled lanes of new data overwrite, no new entry is used, and the merged store never halts.
- Undefined: every store allocates its own entry.

Test Plan:
- Reset with BUS_REQ active mid-write -> BUS_REQ=0 immediately; FIFO empty; DBIU_HALT=0; DBUSMUPIN=0.
- 5 word stores to 0x100..0x110, BUS_ACK held low, WB_DEPTH=4 -> 4 queued, DBIU_HALT=1 on the 5th M cycle. Then ack every 3rd cycle -> bus writes 0x100..0x110 in order, data intact, halt clears on the first pop.
- Store to 0x200 with CP0_XCPN_M=1 in M -> no bus write; FIFO count unchanged.
- Store 0x300=0x11223344, then signed byte load 0x303 with BUS_RDATA=0x80223344 -> write completes before the read; DBUSMUPIN=0xFFFFFF80.
- Unsigned halfword load at 0x402 (byen 1100), BUS_RDATA=0xBEEF1234 -> DBUSMUPIN=0x0000BEEF; halt drops the cycle after ACK.
- With DBUS_WBUF_MERGE_EN: byte stores to 0x500 lanes 0 and 2, bus stalled -> one entry, BUS_BYEN=0101, both bytes in BUS_WDATA. Without the macro -> two entries.
